// File: rtl/conv_window_tagger_pkg.sv
// rtl/conv_window_tagger_pkg.sv - shared types and defaults for conv_window_tagger
// Purpose: FSM state encoding, per-beat tag flags, tagged-beat layout and
//          default kernel/data/counter sizes used by the tagger and its bench.
// Ports:   none (package).
package conv_pkg;

  localparam int DEF_K      = 3;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic win;
    logic sof;
    logic eol;
    logic eof;
  } tag_t;

  // Layout of one tagged beat at the default widths; the top packs the same
  // field order at its own parameterised widths.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_CNT_W-1:0]  col;
    logic [DEF_CNT_W-1:0]  row;
    tag_t                  tag;
  } beat_t;

endpackage

// File: rtl/conv_window_tagger_if.sv
// rtl/conv_window_tagger_if.sv - pixel-in / tagged-pixel-out stream bundle
// Purpose: groups the upstream pixel handshake and the downstream tagged beat.
// Ports:   s_valid/s_ready/s_data (pixel in), m_valid/m_ready/m_data,
//          m_col/m_row/m_win/m_sof/m_eol/m_eof (tagged pixel out).
// Modports: master = stream source/sink side, slave = tagger side.
interface conv_window_tagger_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0]  m_col;
  logic [CNT_W-1:0]  m_row;
  logic              m_win;
  logic              m_sof;
  logic              m_eol;
  logic              m_eof;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_col, m_row, m_win, m_sof, m_eol, m_eof
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_col, m_row, m_win, m_sof, m_eol, m_eof
  );
endinterface

// File: rtl/conv_window_tagger_skid_buffer.sv
// rtl/conv_window_tagger_skid_buffer.sv - generic 2-entry skid buffer
// Purpose: decouples upstream and downstream ready paths; both ready and
//          valid are decoded straight from the occupancy register.
// Ports:   clk, rst (async active-low), s_valid/s_ready/s_data in,
//          m_valid/m_ready/m_data out.
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         in_xfer;
  logic         out_xfer;

  assign in_xfer  = s_valid & s_ready;
  assign out_xfer = m_valid & m_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (in_xfer) begin
        mem[wr_ptr] <= s_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (out_xfer) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({in_xfer, out_xfer})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign s_ready = (cnt != 2'd2);
  assign m_valid = (cnt != 2'd0);
  // Head entry is only rewritten after it is popped, so it holds under stall.
  assign m_data  = mem[rd_ptr];
endmodule

// File: rtl/conv_window_tagger.sv
// rtl/conv_window_tagger.sv - raster pixel tagger with KxK window flag
// Purpose: tags each accepted pixel with col/row, window-complete, sof, eol
//          and eof, and forwards it through a 2-entry skid buffer.
// Ports:   clk, rst (async active-low), start (arms one frame),
//          bus (slave side of conv_window_tagger_if), frame_done (pulse when
//          the frame has drained), busy (FSM not idle).
// Option:  CONV_WINDOW_TAGGER_STRIDE2_EN - window flag only on stride-2 grid.
module conv_window_tagger
  import conv_pkg::*;
#(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int K      = DEF_K,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  conv_window_tagger_if.slave  bus,
  output logic                 frame_done,
  output logic                 busy
);
  localparam logic [CNT_W-1:0] KM1      = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
  localparam int               PW       = DATA_W + 2 * CNT_W + $bits(tag_t);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  tag_t             tag;
  tag_t             m_tag;
  logic             accept_en;
  logic             sb_ready;
  logic             in_xfer;
  logic [PW-1:0]    sb_out;

  // Tags are a function of the coordinates the pixel is accepted at.
  always_comb begin
    tag     = '0;
    tag.win = (col >= KM1) && (row >= KM1);
`ifdef CONV_WINDOW_TAGGER_STRIDE2_EN
    // Offset from K-1 is even exactly when the low bits agree.
    tag.win = tag.win && (col[0] == KM1[0]) && (row[0] == KM1[0]);
`endif
    tag.sof = (col == '0) && (row == '0);
    tag.eol = (col == COL_LAST);
    tag.eof = tag.eol && (row == ROW_LAST);
  end

  assign in_xfer = bus.s_valid & bus.s_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = STREAM;
      STREAM:  if (in_xfer && tag.eof) state_nx = DRAIN;
      DRAIN:   if (!bus.m_valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    accept_en  = (state == STREAM);
    busy       = (state != IDLE);
    frame_done = (state == DRAIN) && !bus.m_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (state == IDLE && start) begin
      col <= '0;
      row <= '0;
    end else if (in_xfer) begin
      if (tag.eol) begin
        col <= '0;
        row <= tag.eof ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign bus.s_ready = accept_en & sb_ready;

  skid_buffer #(.W(PW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_valid (bus.s_valid & accept_en),
    .s_ready (sb_ready),
    .s_data  ({bus.s_data, col, row, tag}),
    .m_valid (bus.m_valid),
    .m_ready (bus.m_ready),
    .m_data  (sb_out)
  );

  assign {bus.m_data, bus.m_col, bus.m_row, m_tag} = sb_out;
  assign bus.m_win = m_tag.win;
  assign bus.m_sof = m_tag.sof;
  assign bus.m_eol = m_tag.eol;
  assign bus.m_eof = m_tag.eof;
endmodule

// File: tb/tb_conv_window_tagger.sv
// tb/tb_conv_window_tagger.sv - scoreboard bench for conv_window_tagger
module tb_conv_window_tagger;
  localparam int K = 3;
`ifdef CONV_WINDOW_TAGGER_STRIDE2_EN
  localparam int W = 6;
  localparam int H = 6;
  localparam int WIN_EXP = 4;
`else
  localparam int W = 4;
  localparam int H = 3;
  localparam int WIN_EXP = (W - K + 1) * (H - K + 1);
`endif
  localparam int N = W * H;

  typedef struct packed {
    logic [7:0]  d;
    logic [15:0] c;
    logic [15:0] r;
    logic        win;
    logic        sof;
    logic        eol;
    logic        eof;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic frame_done;
  logic busy;

  conv_window_tagger_if #(.DATA_W(8), .CNT_W(16)) bus ();

  conv_window_tagger #(
    .IMG_W(W), .IMG_H(H), .K(K), .DATA_W(8), .CNT_W(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus.slave),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   passed = 0;
  exp_t q[$];
  exp_t mon_e;
  int   m_idx = 0;
  int   frame_beats = 0;
  int   win_cnt = 0;
  int   done_cnt = 0;
  bit   eof_prev = 0;
  int   mr_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  // Reference: position inside the frame decides every tag.
  function automatic exp_t model(input int idx, input logic [7:0] d);
    exp_t e;
    int c;
    int r;
    c = idx % W;
    r = idx / W;
    e.d   = d;
    e.c   = 16'(c);
    e.r   = 16'(r);
    e.win = (c >= K - 1) && (r >= K - 1);
`ifdef CONV_WINDOW_TAGGER_STRIDE2_EN
    e.win = e.win && ((c - (K - 1)) % 2 == 0) && ((r - (K - 1)) % 2 == 0);
`endif
    e.sof = (idx == 0);
    e.eol = (c == W - 1);
    e.eof = (idx == N - 1);
    return e;
  endfunction

  function automatic logic [63:0] outs();
    return {bus.s_ready, bus.m_valid, bus.m_data, bus.m_col, bus.m_row,
            bus.m_win, bus.m_sof, bus.m_eol, bus.m_eof, frame_done, busy};
  endfunction

  // Stimulus side: every accepted pixel pushes its expected tagged beat.
  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      m_idx = 0;
    end else if (bus.s_valid && bus.s_ready) begin
      q.push_back(model(m_idx, bus.s_data));
      m_idx = (m_idx + 1) % N;
    end
  end

  // Monitor: compares each delivered beat and the per-frame totals.
  always @(negedge clk) begin
    if (!rst) begin
      frame_beats = 0;
      win_cnt = 0;
      eof_prev = 0;
    end else begin
      if (frame_done) begin
        chk("frame_beats", frame_beats, N);
        chk("frame_wins", win_cnt, WIN_EXP);
        chk("done_after_eof", eof_prev, 1);
        frame_beats = 0;
        win_cnt = 0;
        done_cnt++;
      end
      eof_prev = 0;
      if (bus.m_valid && bus.m_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", q.size(), 1);
        end else begin
          mon_e = q.pop_front();
          chk("beat", {bus.m_data, bus.m_col, bus.m_row, bus.m_win,
                       bus.m_sof, bus.m_eol, bus.m_eof}, mon_e);
        end
        frame_beats++;
        if (bus.m_win) win_cnt++;
        eof_prev = bus.m_eof;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    case (mr_mode)
      0:       bus.m_ready = 1'b1;
      1:       bus.m_ready = 1'($urandom_range(0, 1));
      default: bus.m_ready = 1'b0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit gaps);
    bit acc;
    int guard;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.s_valid = 1'b0;
        tick();
      end
    end
    bus.s_valid = 1'b1;
    bus.s_data = d;
    acc = 0;
    guard = 0;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = bus.s_ready;
      tick();
      guard++;
    end
    chk("send_accepted", acc, 1);
    bus.s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = frame_done;
      tick();
    end
    chk("frame_done_seen", seen, 1);
  endtask

  initial begin
    bit acc;
    rst = 1'b0;
    start = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = 8'd0;
    bus.m_ready = 1'b0;
    mr_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 0);
    rst = 1'b1;
    tick();

    // Pixel offered while idle must wait for start.
    bus.s_valid = 1'b1;
    bus.s_data = 8'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_s_ready", bus.s_ready, 0);
      chk("idle_m_valid", bus.m_valid, 0);
      tick();
    end
    pulse_start();
    for (int i = 0; i < N; i++) send(8'(i), 0);
    wait_done();
    @(negedge clk);
    chk("idle_after_done", busy, 0);
    tick();

    // Backpressure: two accepts fill the buffer, head beat holds.
    mr_mode = 2;
    pulse_start();
    bus.s_valid = 1'b1;
    bus.s_data = 8'h40;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_s_ready", bus.s_ready, (i < 2));
      if (i >= 1)
        chk("bp_hold", {bus.m_valid, bus.m_data, bus.m_col, bus.m_row, bus.m_sof},
            {1'b1, 8'h40, 16'd0, 16'd0, 1'b1});
      acc = bus.s_ready;
      tick();
      if (acc) bus.s_data = bus.s_data + 8'd1;
    end
    bus.s_valid = 1'b0;
    mr_mode = 0;
    for (int i = 2; i < N; i++) send(8'(8'h40 + i), 1);
    wait_done();

    // Reset with a full buffer mid-frame.
    mr_mode = 2;
    pulse_start();
    send(8'h60, 0);
    send(8'h61, 0);
    @(negedge clk);
    chk("pre_reset_full", bus.s_ready, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("midframe_reset_outputs", outs(), 0);
    tick();
    tick();
    mr_mode = 0;
    rst = 1'b1;
    tick();
    pulse_start();
    for (int i = 0; i < N; i++) send(8'($urandom), 1);
    wait_done();

    // Random back-to-back frames; a start during drain must be ignored.
    mr_mode = 1;
    for (int f = 0; f < 3; f++) begin
      pulse_start();
      for (int i = 0; i < N; i++) send(8'($urandom), 1);
      start = 1'b1;
      @(negedge clk);
      chk("drain_busy", busy, 1);
      chk("drain_s_ready", bus.s_ready, 0);
      tick();
      start = 1'b0;
      wait_done();
      @(negedge clk);
      chk("drain_start_ignored", busy, 0);
      tick();
    end

    mr_mode = 0;
    repeat (5) tick();
    chk("queue_drained", q.size(), 0);
    chk("done_count", done_cnt, 6);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
